bound_flasher_seq: RTL and testbench

Parametrised lamp-bar sequencer, next generation of the 16-lamp bound flasher. Drives a NUM_LAMP-wide thermometer lamp bar through a six-phase up/down bounce pattern with configurable turn-around bounds. `flick` kick-back moves the bar back to an earlier phase. Adds a phase/busy/done status interface and an optional step prescaler. Sits between the board-level button synchroniser and the LED pin driver.

---
 rtl/bound_flasher_seq.sv | 183 ++++++++++++++++++
 tb/tb_bound_flasher_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_seq.sv
// Parametrised bound flasher: thermometer lamp bar bouncing through six up/down phases.
// Optional step prescaler and sticky flick latch enabled by FLASHER_PRESCALE_EN.
module bound_flasher_seq #(
    parameter int NUM_LAMP = 16,
    parameter int MID_LO   = 5,
    parameter int MID_HI   = 10,
    parameter int STEP_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flick,
    output logic [NUM_LAMP-1:0] lamp,
    output logic [2:0]          phase,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(NUM_LAMP + 1);
    localparam logic [CW-1:0] C_ZERO = '0;
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_MAX  = CW'(NUM_LAMP);
    localparam logic [CW-1:0] C_LO   = CW'(MID_LO);
    localparam logic [CW-1:0] C_HI   = CW'(MID_HI);

    if (NUM_LAMP < 2 || NUM_LAMP > 64) begin : g_bad_num_lamp
        $error("bound_flasher_seq: NUM_LAMP out of range");
    end
    if (MID_LO < 1 || MID_LO >= MID_HI || MID_HI >= NUM_LAMP) begin : g_bad_bounds
        $error("bound_flasher_seq: illegal MID_LO/MID_HI");
    end
    if (STEP_DIV < 1) begin : g_bad_div
        $error("bound_flasher_seq: STEP_DIV must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP_A = 3'd1,
        DN_A = 3'd2,
        UP_B = 3'd3,
        DN_B = 3'd4,
        UP_C = 3'd5,
        DN_C = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_tick;
    logic          w_flick;

`ifdef FLASHER_PRESCALE_EN
    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

    logic [DW-1:0] r_div;
    logic          r_flick_latch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_flick_latch <= 1'b0;
        end else begin
            if (w_tick) begin
                r_div         <= '0;
                r_flick_latch <= 1'b0;
            end else begin
                r_div <= r_div + DW'(1);
                if (flick) begin
                    r_flick_latch <= 1'b1;
                end
            end
        end
    end

    // A flick seen on the tick cycle itself is honoured along with the latched ones.
    assign w_tick  = (r_div == DIV_LAST);
    assign w_flick = r_flick_latch | flick;
`else
    assign w_tick  = 1'b1;
    assign w_flick = flick;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (w_flick) begin
                        w_state_nxt = UP_A;
                        w_count_nxt = C_ONE;
                    end
                end
                UP_A: begin
                    if (r_count != C_MAX) begin
                        w_count_nxt = r_count + C_ONE;
                    end else begin
                        w_state_nxt = DN_A;
                        w_count_nxt = r_count - C_ONE;
                    end
                end
                DN_A: begin
                    if (r_count != C_LO) begin
                        w_count_nxt = r_count - C_ONE;
                    end else begin
                        w_state_nxt = w_flick ? UP_A : UP_B;
                        w_count_nxt = r_count + C_ONE;
                    end
                end
                UP_B: begin
                    if (r_count != C_HI) begin
                        w_count_nxt = r_count + C_ONE;
                    end else begin
                        w_state_nxt = DN_B;
                        w_count_nxt = r_count - C_ONE;
                    end
                end
                DN_B: begin
                    if (r_count != C_ZERO) begin
                        w_count_nxt = r_count - C_ONE;
                    end else begin
                        w_state_nxt = w_flick ? UP_B : UP_C;
                        w_count_nxt = r_count + C_ONE;
                    end
                end
                UP_C: begin
                    if (r_count != C_LO) begin
                        w_count_nxt = r_count + C_ONE;
                    end else begin
                        w_state_nxt = DN_C;
                        w_count_nxt = r_count - C_ONE;
                    end
                end
                DN_C: begin
                    if (r_count != C_ZERO) begin
                        w_count_nxt = r_count - C_ONE;
                    end else begin
                        w_done_nxt = 1'b1;
                        if (w_flick) begin
                            w_state_nxt = UP_A;
                            w_count_nxt = C_ONE;
                        end else begin
                            w_state_nxt = IDLE;
                            w_count_nxt = C_ZERO;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_count_nxt = C_ZERO;
                end
            endcase
        end
    end

    always_comb begin
        lamp = '0;
        for (int unsigned i = 0; i < NUM_LAMP; i++) begin
            lamp[i] = (i < 32'(r_count));
        end
    end

    assign phase = r_state;
    assign busy  = (r_state != IDLE);
    assign done  = r_done;

endmodule

// File: tb/tb_bound_flasher_seq.sv
// Directed bench for bound_flasher_seq: per-cycle scoreboard against a behavioural model
// plus fixed checkpoints from the reference sequence (FLASHER_PRESCALE_EN selects the prescaler run).
module tb_bound_flasher_seq;

    localparam int NL = 16;
    localparam int LO = 5;
    localparam int HI = 10;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flick = 1'b0;
    logic [NL-1:0] lamp;
    logic [2:0]    phase;
    logic          busy;
    logic          done;

    bound_flasher_seq #(
        .NUM_LAMP(NL),
        .MID_LO  (LO),
        .MID_HI  (HI),
        .STEP_DIV(SD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flick(flick),
        .lamp (lamp),
        .phase(phase),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    ph;
        logic [NL-1:0] lp;
        logic          by;
        logic          dn;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   m_phase = 0;
    int   m_count = 0;
    int   m_div   = 0;
    bit   m_latch = 1'b0;
    bit   m_done  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bnd(input int p);
        case (p)
            1:       return NL;
            2:       return LO;
            3:       return HI;
            5:       return LO;
            default: return 0;
        endcase
    endfunction

    task automatic model(input bit flk, input bit r);
        bit tick;
        bit eff;
        m_done = 1'b0;
        if (r) begin
            m_phase = 0;
            m_count = 0;
            m_div   = 0;
            m_latch = 1'b0;
            return;
        end
`ifdef FLASHER_PRESCALE_EN
        tick    = (m_div == SD - 1);
        eff     = m_latch | flk;
        m_div   = tick ? 0 : m_div + 1;
        m_latch = tick ? 1'b0 : (m_latch | flk);
`else
        tick = 1'b1;
        eff  = flk;
`endif
        if (!tick) return;
        if (m_phase == 0) begin
            if (eff) begin
                m_phase = 1;
                m_count = 1;
            end
        end else if (m_count != bnd(m_phase)) begin
            m_count = m_count + (((m_phase % 2) == 1) ? 1 : -1);
        end else begin
            case (m_phase)
                1, 3, 5: begin m_phase = m_phase + 1; m_count = m_count - 1; end
                2:       begin m_phase = eff ? 1 : 3; m_count = m_count + 1; end
                4:       begin m_phase = eff ? 3 : 5; m_count = m_count + 1; end
                default: begin
                    m_done  = 1'b1;
                    m_phase = eff ? 1 : 0;
                    m_count = eff ? 1 : 0;
                end
            endcase
        end
    endtask

    task automatic step(input bit flk, input bit r);
        exp_t e;
        exp_t g;
        logic [63:0] thermo;
        rst   = r;
        flick = flk;
        model(flk, r);
        thermo = (64'(1) << m_count) - 64'(1);
        e.ph = 3'(m_phase);
        e.lp = thermo[NL-1:0];
        e.by = (m_phase != 0);
        e.dn = m_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("phase", 32'(phase), 32'(g.ph));
        chk("lamp", 32'(lamp), 32'(g.lp));
        chk("busy", 32'(busy), 32'(g.by));
        chk("done", 32'(done), 32'(g.dn));
    endtask

    initial begin
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("rst_lamp", 32'(lamp), 32'h0);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

`ifndef FLASHER_PRESCALE_EN
        // Reference sequence, single flick at E0.
        for (int e = 0; e <= 53; e++) begin
            step(e == 0, 1'b0);
            if (e == 0)  chk("E0_lamp", 32'(lamp), 32'h0001);
            if (e == 15) chk("E15_lamp", 32'(lamp), 32'hFFFF);
            if (e == 26) chk("E26_lamp", 32'(lamp), 32'h001F);
            if (e == 31) chk("E31_lamp", 32'(lamp), 32'h03FF);
            if (e == 41) chk("E41_lamp", 32'(lamp), 32'h0000);
            if (e == 46) chk("E46_lamp", 32'(lamp), 32'h001F);
            if (e == 51) chk("E51_lamp", 32'(lamp), 32'h0000);
            if (e == 52) begin
                chk("E52_done", 32'(done), 32'h1);
                chk("E52_busy", 32'(busy), 32'h0);
                chk("E52_lamp", 32'(lamp), 32'h0000);
            end
            if (e == 53) chk("E53_done", 32'(done), 32'h0);
        end
        step(1'b0, 1'b0);
        chk("idle_hold", 32'(phase), 32'h0);
        step(1'b0, 1'b1);

        // Kick-back at DN_A bound; flick mid UP_A is ignored.
        for (int e = 0; e <= 37; e++) begin
            step(e == 0 || e == 5 || e == 27, 1'b0);
            if (e == 27) begin
                chk("E27_phase", 32'(phase), 32'h1);
                chk("E27_lamp", 32'(lamp), 32'h003F);
            end
            if (e == 37) chk("E37_lamp", 32'(lamp), 32'hFFFF);
        end
        step(1'b0, 1'b1);

        // Kick-back at DN_B bound.
        for (int e = 0; e <= 51; e++) begin
            step(e == 0 || e == 42, 1'b0);
            if (e == 42) begin
                chk("E42_phase", 32'(phase), 32'h3);
                chk("E42_lamp", 32'(lamp), 32'h0001);
            end
            if (e == 51) chk("E51k_lamp", 32'(lamp), 32'h03FF);
        end
        step(1'b0, 1'b1);

        // Restart on completion.
        for (int e = 0; e <= 52; e++) begin
            step(e == 0 || e == 52, 1'b0);
            if (e == 52) begin
                chk("restart_done", 32'(done), 32'h1);
                chk("restart_busy", 32'(busy), 32'h1);
                chk("restart_phase", 32'(phase), 32'h1);
                chk("restart_lamp", 32'(lamp), 32'h0001);
            end
        end
        step(1'b0, 1'b0);
        chk("restart_done_low", 32'(done), 32'h0);
        step(1'b0, 1'b1);

        // Reset mid-sequence with flick high.
        for (int e = 0; e <= 11; e++) begin
            step(e == 0, 1'b0);
        end
        chk("pre_rst_lamp", 32'(lamp), 32'h0FFF);
        step(1'b1, 1'b1);
        chk("midrst_lamp", 32'(lamp), 32'h0);
        chk("midrst_phase", 32'(phase), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
        end
        chk("no_start", 32'(phase), 32'h0);
        step(1'b1, 1'b0);
        chk("start_phase", 32'(phase), 32'h1);
        chk("start_lamp", 32'(lamp), 32'h0001);
        step(1'b0, 1'b1);
`else
        // Prescaled run: kick-back from a short flick pulse two cycles before the DN_A bound tick.
        begin
            int n;
            step(1'b1, 1'b0);
            n = 0;
            while (!(m_phase == 2 && m_count == LO && m_div == 1) && n < 400) begin
                step(1'b0, 1'b0);
                n++;
            end
            chk("reach_dn_a_bound", 32'(n < 400), 32'h1);
            chk("at_bound_lamp", 32'(lamp), 32'h001F);
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            chk("latched_no_tick", 32'(phase), 32'h2);
            step(1'b0, 1'b0);
            chk("pre_kick_phase", 32'(phase), 32'h1);
            chk("pre_kick_lamp", 32'(lamp), 32'h003F);
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b0);
                chk("hold_between_ticks", 32'(lamp), 32'h003F);
            end
            step(1'b0, 1'b0);
            chk("next_tick_lamp", 32'(lamp), 32'h007F);
            step(1'b0, 1'b1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
